// File: rtl/fifo_flush_ctrl.sv
// Write-side arbiter and flush scheduler for the fifo_flush nibble-packing FIFO.
// Build macro FIFO_FLUSH_AUTO_EN enables the write-idle auto-flush timer.
module fifo_flush_ctrl #(
  parameter int unsigned IDLE_TIMEOUT = 8,
  parameter int unsigned FLUSH_TMO    = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid_i,
  input  logic [3:0] req0_data_i,
  output logic       req0_ready_o,
  input  logic       req1_valid_i,
  input  logic [3:0] req1_data_i,
  output logic       req1_ready_o,
  input  logic       flush_req_i,
  input  logic       rd_ready_i,
  input  logic       fifo_full_i,
  input  logic       fifo_data_avail_i,
  input  logic       fifo_flush_done_i,
  output logic       fifo_wr_valid_o,
  output logic [3:0] fifo_wr_data_o,
  output logic       fifo_rd_valid_o,
  output logic       fifo_flush_o,
  output logic       busy_o,
  output logic       flush_err_o,
  output logic [2:0] nib_cnt_o
);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_e;

  state_e     state_q, state_d;
  logic       rr_q, rr_d;
  logic [2:0] nib_q, nib_d;
  logic [7:0] wdog_q, wdog_d;
  logic       pend_q, pend_d;
  logic       err_q, err_d;

  logic run, contend, gnt1, wr_acc, tmo_hit, auto_trig, flush_exit;

  // Reset also gates the combinational write path so nothing is accepted while held.
  assign run        = (state_q == RUN) && reset;
  assign contend    = req0_valid_i && req1_valid_i;
  assign gnt1       = contend ? rr_q : req1_valid_i;
  assign wr_acc     = run && !fifo_full_i && (req0_valid_i || req1_valid_i);
  assign tmo_hit    = (wdog_q == 8'(FLUSH_TMO - 1));
  assign flush_exit = (state_q == FLUSH) && (fifo_flush_done_i || tmo_hit);

  assign req0_ready_o    = wr_acc && !gnt1;
  assign req1_ready_o    = wr_acc && gnt1;
  assign fifo_wr_valid_o = wr_acc;
  assign fifo_wr_data_o  = wr_acc ? (gnt1 ? req1_data_i : req0_data_i) : 4'h0;
  assign fifo_rd_valid_o = rd_ready_i && fifo_data_avail_i;
  assign fifo_flush_o    = (state_q == FLUSH);
  assign busy_o          = (state_q == FLUSH);
  assign flush_err_o     = err_q;
  assign nib_cnt_o       = nib_q;

`ifdef FIFO_FLUSH_AUTO_EN
  logic [7:0] idle_q, idle_d;

  assign auto_trig = (idle_q == 8'(IDLE_TIMEOUT));

  always_comb begin
    idle_d = idle_q;
    if (state_q != RUN || wr_acc || nib_q == 3'd0) begin
      idle_d = 8'd0;
    end else if (idle_q != 8'(IDLE_TIMEOUT)) begin
      idle_d = idle_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) idle_q <= 8'd0;
    else        idle_q <= idle_d;
  end
`else
  // No idle timer in this build; the parameter only keeps the instantiation uniform.
  assign auto_trig = 1'b0 && (IDLE_TIMEOUT != 0);
`endif

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    nib_d   = nib_q;
    wdog_d  = wdog_q;
    pend_d  = pend_q;
    err_d   = err_q;
    case (state_q)
      RUN: begin
        if (wr_acc) begin
          nib_d = nib_q + 3'd1;
          if (contend) rr_d = ~rr_q;
        end
        if (flush_req_i) pend_d = 1'b1;
        if (flush_req_i || pend_q || auto_trig) begin
          state_d = FLUSH;
          wdog_d  = 8'd0;
        end
      end
      FLUSH: begin
        if (flush_exit) begin
          state_d = RUN;
          nib_d   = 3'd0;
          wdog_d  = 8'd0;
          pend_d  = 1'b0;
          if (!fifo_flush_done_i) err_d = 1'b1;
        end else begin
          wdog_d = wdog_q + 8'd1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      rr_q    <= 1'b0;
      nib_q   <= 3'd0;
      wdog_q  <= 8'd0;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      nib_q   <= nib_d;
      wdog_q  <= wdog_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
    end
  end

endmodule
